// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_DV, START, DATA, STOP} uart_tx_state_t;

    localparam int CLKS_PER_BIT_115200_50M = 434;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port handshake between the FIFO (slave) and the UART transmitter (master).
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
) ();

    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             fifo_rd_dv;
    logic [WIDTH-1:0] fifo_rd_data;

    modport master (
        input  fifo_empty,
        output fifo_rd_en,
        input  fifo_rd_dv,
        input  fifo_rd_data
    );

    modport slave (
        output fifo_empty,
        input  fifo_rd_en,
        output fifo_rd_dv,
        output fifo_rd_data
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, ticks on the last count, clears on clr_i or tick.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o,
    output logic last_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (clr_i || tick_o) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // last_o flags the clock before the tick so registered outputs can land on the tick clock.
    assign tick_o = !clr_i && (cnt_reg == CNT_MAX);
    assign last_o = !clr_i && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls one word at a time from a FIFO read port and sends it as an 8N1 UART frame on tx_o.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_50M,
    parameter int DV_TIMEOUT   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fifo_uart_tx_if.master   fifo,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int DV_W  = $clog2(DV_TIMEOUT + 1);

    uart_tx_state_t   state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [DV_W-1:0]  dv_cnt_reg;
    logic             tx_reg;
    logic             rd_en_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    logic timer_clr;
    logic timer_tick;
    logic timer_last;

    // Holding the timer clear outside the timed states guarantees a fresh count on entry to START;
    // START->DATA->STOP->IDLE all happen on a tick, which self-clears the counter.
    assign timer_clr = (state_reg == IDLE) || (state_reg == WAIT_DV);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (timer_clr),
        .tick_o(timer_tick),
        .last_o(timer_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            dv_cnt_reg  <= '0;
            tx_reg      <= 1'b1;
            rd_en_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            rd_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo.fifo_empty) begin
                        rd_en_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                        dv_cnt_reg <= '0;
                        state_reg  <= WAIT_DV;
                    end
                end
                WAIT_DV: begin
                    if (fifo.fifo_rd_dv) begin
                        shift_reg   <= fifo.fifo_rd_data;
                        bit_idx_reg <= '0;
                        tx_reg      <= 1'b0;
                        state_reg   <= START;
                    end else if (dv_cnt_reg == DV_W'(DV_TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        dv_cnt_reg <= dv_cnt_reg + 1'b1;
                    end
                end
                START: begin
                    if (timer_tick) begin
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (timer_tick) begin
                        if (bit_idx_reg == IDX_W'(WIDTH - 1)) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (timer_last) begin
                        done_reg <= 1'b1;
                    end
                    if (timer_tick) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign fifo.fifo_rd_en = rd_en_reg;
    assign tx_o            = tx_reg;
    assign busy_o          = busy_reg;
    assign done_o          = done_reg;
    assign err_o           = err_reg;

endmodule
